// File: rtl/accum_arbiter_pkg.sv
// Shared types and defaults for the two-requester accumulating arbiter.
package accum_arbiter_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BEATS = 16;

    // Requester identifier: one bit selects requester 0 or 1.
    typedef logic req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

endpackage : accum_arbiter_pkg

// File: rtl/accum_add_step.sv
// Combinational WIDTH-bit add step: wrapped sum, unsigned carry-out and
// signed overflow of a single accumulate beat.
module accum_add_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf
);

    logic [WIDTH:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum   = w_full[WIDTH-1:0];
    assign o_carry = w_full[WIDTH];
    // Overflow when both operands share a sign that the sum does not.
    assign o_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule : accum_add_step

// File: rtl/accum_arbiter.sv
// Round-robin arbiter between two operand streams; sums one burst of the
// granted requester and presents the result with overflow/carry/trunc flags.
module accum_arbiter
    import accum_arbiter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req_valid,
    input  logic [WIDTH-1:0] i_req_data0,
    input  logic [WIDTH-1:0] i_req_data1,
    input  logic [1:0]       i_req_last,
    output logic [1:0]       o_req_ready,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_res_data,
    output logic             o_res_id,
    output logic             o_res_ovf,
    output logic             o_res_carry,
    output logic             o_res_trunc,
    output logic             o_busy
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    state_t          r_state;
    state_t          w_state_next;
    req_id_t         r_ptr;
    req_id_t         r_grant;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic            r_carry;
    logic            r_trunc;

    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_sum;
    logic            w_carry;
    logic            w_ovf;
    logic            w_fire;
    logic            w_last;
    logic            w_at_max;
    logic [CW-1:0]   w_cnt_next;
    req_id_t         w_pick;
    logic            w_in_result;

    assign w_data      = r_grant ? i_req_data1 : i_req_data0;
    assign w_fire      = (r_state == ST_ACCUM) && i_req_valid[r_grant];
    assign w_last      = i_req_last[r_grant];
    assign w_cnt_next  = r_cnt + 1'b1;
    assign w_at_max    = (w_cnt_next == CW'(MAX_BEATS));
    assign w_pick      = i_req_valid[r_ptr] ? r_ptr : ~r_ptr;
    assign w_in_result = (r_state == ST_RESULT);

    accum_add_step #(.WIDTH(WIDTH)) u_add (
        .i_a     (r_acc),
        .i_b     (w_data),
        .o_sum   (w_sum),
        .o_carry (w_carry),
        .o_ovf   (w_ovf)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and beat-accept strobe.
    always_comb begin
        w_state_next = r_state;
        o_req_ready  = '0;
        case (r_state)
            ST_IDLE: begin
                if (|i_req_valid) w_state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                o_req_ready[r_grant] = 1'b1;
                if (w_fire && (w_last || w_at_max)) w_state_next = ST_RESULT;
            end
            ST_RESULT: begin
                if (i_res_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Grant, pointer, accumulator and flag registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr   <= 1'b0;
            r_grant <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_carry <= 1'b0;
            r_trunc <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|i_req_valid) begin
                        r_grant <= w_pick;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_carry <= 1'b0;
                        r_trunc <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (w_fire) begin
                        r_acc   <= w_sum;
                        r_cnt   <= w_cnt_next;
                        r_ovf   <= r_ovf | w_ovf;
                        r_carry <= w_carry;
                        r_trunc <= w_at_max && !w_last;
                    end
                end
                ST_RESULT: begin
                    if (i_res_ready) r_ptr <= ~r_grant;
                end
                default: ;
            endcase
        end
    end

    // Result fields are only driven while a result is being offered.
    assign o_res_valid = w_in_result;
    assign o_res_data  = w_in_result ? r_acc : '0;
    assign o_res_id    = w_in_result & r_grant;
    assign o_res_ovf   = w_in_result & r_ovf;
    assign o_res_carry = w_in_result & r_carry;
    assign o_res_trunc = w_in_result & r_trunc;
    assign o_busy      = (r_state != ST_IDLE);

endmodule : accum_arbiter

// File: tb/tb_accum_arbiter.sv
// Directed self-checking bench for accum_arbiter.
module tb_accum_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] req_last;
    logic [1:0] req_ready;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_id;
    logic       res_ovf;
    logic       res_carry;
    logic       res_trunc;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    accum_arbiter #(.WIDTH(8), .MAX_BEATS(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data0 (data0),
        .i_req_data1 (data1),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_data  (res_data),
        .o_res_id    (res_id),
        .o_res_ovf   (res_ovf),
        .o_res_carry (res_carry),
        .o_res_trunc (res_trunc),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat on requester id and wait (bounded) for it to transfer.
    task automatic send_beat(input int id, input logic [7:0] d, input logic lst);
        int n;
        n = 0;
        if (id == 0) data0 = d; else data1 = d;
        req_valid     = 2'b00;
        req_last      = 2'b00;
        req_valid[id] = 1'b1;
        req_last[id]  = lst;
        while (!req_ready[id] && n < 20) begin
            tick();
            n++;
        end
        check("beat_accept", {31'd0, req_ready[id]}, 32'd1);
        if (req_ready[id]) tick();
        req_valid = 2'b00;
        req_last  = 2'b00;
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_idle_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_idle_busy"},  {31'd0, busy},      32'd0);
    endtask

    task automatic check_result(input string tag, input logic [7:0] d, input logic id,
                                input logic ovf, input logic carry, input logic trunc);
        check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_data"},  {24'd0, res_data},  {24'd0, d});
        check({tag, "_id"},    {31'd0, res_id},    {31'd0, id});
        check({tag, "_ovf"},   {31'd0, res_ovf},   {31'd0, ovf});
        check({tag, "_carry"}, {31'd0, res_carry}, {31'd0, carry});
        check({tag, "_trunc"}, {31'd0, res_trunc}, {31'd0, trunc});
        check({tag, "_ready"}, {30'd0, req_ready}, 32'd0);
    endtask

    initial begin
        int    beats;
        int    n;
        int    exp_id;
        logic [7:0] held;

        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        data0     = '0;
        data1     = '0;
        res_ready = 1'b0;
        #1;
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_ready", {30'd0, req_ready}, 32'd0);
        check("rst_data",  {24'd0, res_data},  32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Req0: 17 + 75 - 63 - 36 = -7.
        send_beat(0, 8'h11, 1'b0);
        send_beat(0, 8'h4B, 1'b0);
        send_beat(0, 8'hC1, 1'b0);
        send_beat(0, 8'hDC, 1'b1);
        check_result("b034", 8'hF9, 1'b0, 1'b0, 1'b0, 1'b0);
        handshake("b034");

        // Req1: 93 + 93 overflows to -70, no carry.
        send_beat(1, 8'h5D, 1'b0);
        send_beat(1, 8'h5D, 1'b1);
        check_result("b035a", 8'hBA, 1'b1, 1'b1, 1'b0, 1'b0);
        handshake("b035a");

        // Req1: -37 x4 -> -148 wraps to 108, ovf and carry on final add.
        send_beat(1, 8'hDB, 1'b0);
        send_beat(1, 8'hDB, 1'b0);
        send_beat(1, 8'hDB, 1'b0);
        send_beat(1, 8'hDB, 1'b1);
        check_result("b035b", 8'h6C, 1'b1, 1'b1, 1'b1, 1'b0);
        handshake("b035b");

        // Result held under backpressure for 3 cycles, then accepted.
        send_beat(0, 8'h05, 1'b0);
        send_beat(0, 8'h06, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_result("hold", 8'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        check_result("hold4", 8'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
        handshake("hold");

        // Req0 sends 1 continuously without last: truncated at 16 beats.
        data0     = 8'h01;
        req_valid = 2'b01;
        req_last  = 2'b00;
        beats     = 0;
        n         = 0;
        while (!res_valid && n < 40) begin
            if (req_ready[0]) beats++;
            tick();
            n++;
        end
        check("trunc_beats", beats, 16);
        check_result("trunc", 8'h10, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("trunc_no17", {30'd0, req_ready}, 32'd0);
        req_valid = '0;
        handshake("trunc");

        // Reset pulsed two beats into a burst discards it.
        send_beat(0, 8'h0A, 1'b0);
        send_beat(0, 8'h14, 1'b0);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  {31'd0, busy},      32'd0);
        check("mid_rst_ready", {30'd0, req_ready}, 32'd0);
        check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        tick();
        rst = 1'b0;

        // Both requesters valid: req0 first after reset, then alternate.
        data0     = 8'h03;
        data1     = 8'h04;
        req_valid = 2'b11;
        req_last  = 2'b11;
        res_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            exp_id = (k / 3) % 2;
            check("rr_not_both", {31'd0, (req_ready == 2'b11)}, 32'd0);
            case (k % 3)
                0: check("rr_ready", {30'd0, req_ready}, (exp_id == 0) ? 32'd1 : 32'd2);
                1: begin
                    held = (exp_id == 0) ? 8'h03 : 8'h04;
                    check("rr_valid", {31'd0, res_valid}, 32'd1);
                    check("rr_id",    {31'd0, res_id},    exp_id);
                    check("rr_data",  {24'd0, res_data},  {24'd0, held});
                end
                default: check("rr_idle", {31'd0, busy}, 32'd0);
            endcase
        end
        req_valid = '0;
        res_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_accum_arbiter

// File: doc/accum_arbiter.md
ACCUM_ARBITER -- requirements
Module: accum_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand/accumulator width in bits (two's complement).
REQ-002 Parameter: MAX_BEATS, 16, maximum operand beats per burst before forced termination.
REQ-003 i_clk  input  1  single clock, all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req_valid  input  2  per-requester operand valid, bit n = requester n.
REQ-006 i_req_data0 / i_req_data1  input  WIDTH  signed operand of requester 0 / 1.
REQ-007 i_req_last  input  2  per-requester final-beat marker, qualified by valid.
REQ-008 o_req_ready  output  2  per-requester beat accept; at most one bit high.
REQ-009 o_res_valid  output  1  burst result available.
REQ-010 i_res_ready  input  1  result consumer accept.
REQ-011 o_res_data  output  WIDTH  signed burst sum, modulo 2^WIDTH.
REQ-012 o_res_id  output  1  requester that owned the burst.
REQ-013 o_res_ovf  output  1  sticky signed overflow over the burst.
REQ-014 o_res_carry  output  1  unsigned carry-out of the last accepted add.
REQ-015 o_res_trunc  output  1  burst ended by MAX_BEATS, not by last.
REQ-016 o_busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, ACCUM, RESULT.
REQ-018 IDLE: when any i_req_valid is high, grant goes to requester at round-robin pointer if valid, else the other; next state ACCUM; accumulator, beat count, ovf, carry, trunc cleared to 0.
REQ-019 IDLE consumes no beat; o_req_ready is 0 in IDLE and RESULT.
REQ-020 ACCUM: o_req_ready[grant]=1, other bit 0; a beat transfers when valid&ready.
REQ-021 Per beat: acc <= acc + data (WIDTH-bit wrap); ovf <= ovf | (operand signs equal and sum sign differs); carry <= unsigned carry-out of this add; beat count +1.
REQ-022 Non-granted requester is never accepted mid-burst, regardless of its valid.
REQ-023 Beat with last=1 -> RESULT next cycle; beat that makes count = MAX_BEATS without last -> RESULT with trunc=1; last on beat MAX_BEATS -> trunc=0.
REQ-024 Latency: o_res_valid high the cycle after the final beat transfer.
REQ-025 RESULT: o_res_* stable while o_res_valid=1 and i_res_ready=0.
REQ-026 RESULT with i_res_ready=1 -> IDLE next cycle, pointer set to the other requester; o_res_valid low in IDLE.
REQ-027 Back-to-back: new grant no earlier than the cycle after result handshake (one IDLE cycle minimum).
REQ-028 Valid dropping mid-burst stalls ACCUM indefinitely; no timeout.

Reset
REQ-029 i_rst high: state IDLE, pointer = requester 0, acc/count/flags 0, all outputs 0, immediately (asynchronous).
REQ-030 Reset mid-burst or in RESULT discards partial sum; no result emitted for that burst.
REQ-031 First edge after reset release follows IDLE rules.

Structure
REQ-032 Package accum_arbiter_pkg holds state enum, WIDTH default, MAX_BEATS default, requester-id type.
REQ-033 One sub-module accum_add_step: combinational WIDTH-bit signed add giving sum, carry, ovf; arbiter holds all registers.

Verification
REQ-034 Req0 beats 17, 75, -63, -36(last) -> result -7 (0xF9), id 0, ovf 0, trunc 0, valid one cycle after last beat.
REQ-035 Req1 beats 93, 93(last) -> result -70 (0xBA), ovf 1, carry 0; req1 beats -37 x4, last on 4th -> result 108 (0x6C), ovf 1, carry 1.
REQ-036 After reset both valid continuously -> req0 burst served first, then req1, then req0; o_req_ready never 2'b11.
REQ-037 Req0 sends 1 for 16 beats, last never set -> result 16, trunc 1; 17th beat not accepted in that burst.
REQ-038 i_res_ready held 0 for 3 cycles in RESULT -> o_res_* stable, o_req_ready 0; handshake on 4th cycle -> IDLE next cycle.
REQ-039 i_rst pulsed after 2 beats of a burst -> outputs 0 at once, no result; next burst starts from 0 with req0 priority.
